// File: rtl/mem_arbiter_pkg.sv
// Shared state, owner and address-field definitions for the two-requester memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT1 = 2'd2,
        WAIT2 = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    localparam int BANK_LSB          = 1;
    localparam int BANK_MSB          = 2;
    localparam int ISSUE_TO_DONE_LAT = 2;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way owner selector with a last-winner pointer.
// Build option ARB_FIXED_PRIO_EN: the data side always wins a simultaneous request.
module arb_rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  logic   take_i,
    output logic   valid_o,
    output owner_e owner_o
);

    owner_e last_q, last_d;

    always_comb begin
        valid_o = i_req_i | d_req_i;
        owner_o = OWNER_I;
        if (i_req_i && d_req_i) begin
`ifdef ARB_FIXED_PRIO_EN
            owner_o = OWNER_D;
`else
            owner_o = (last_q == OWNER_D) ? OWNER_I : OWNER_D;
`endif
        end else if (d_req_i) begin
            owner_o = OWNER_D;
        end
        last_d = take_i ? owner_o : last_q;
    end

    // Resetting to "instruction won last" gives the data side the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWNER_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data memory arbiter: one outstanding banked access, fixed 2-cycle issue-to-done.
// Build option ARB_FIXED_PRIO_EN selects fixed data-side priority inside arb_rr_pick.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        i_grant,
    output logic        d_grant,
    output logic        i_done,
    output logic        d_done,
    output logic        i_err,
    output logic        d_err,
    output logic [15:0] rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic [3:0]  mem_busy,
    input  logic        mem_stall,
    input  logic        mem_err
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;

    logic        pick_valid;
    owner_e      pick_owner;
    logic        take;
    logic [1:0]  bank;
    logic        can_issue;
    logic        in_txn;
    logic        err_now;

    arb_rr_pick u_pick (
        .clk     (clk),
        .rst     (rst),
        .i_req_i (i_req),
        .d_req_i (d_req),
        .take_i  (take),
        .valid_o (pick_valid),
        .owner_o (pick_owner)
    );

    assign bank      = addr_q[BANK_MSB:BANK_LSB];
    assign can_issue = !mem_busy[bank] && !mem_stall;
    assign in_txn    = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (pick_valid) begin
                    take    = 1'b1;
                    owner_d = pick_owner;
                    state_d = ISSUE;
                    // The instruction side is read-only, so it never latches a write.
                    if (pick_owner == OWNER_D) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        wr_d    = d_wr;
                    end else begin
                        addr_d  = i_addr;
                        wdata_d = 16'h0000;
                        wr_d    = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (can_issue) begin
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                if (mem_err) begin
                    err_d = 1'b1;
                end
                state_d = WAIT2;
            end
            WAIT2: begin
                if (!wr_q) begin
                    rdata_d = mem_rdata;
                end
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWNER_I;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // An error seen in the done cycle itself still reaches the owner with that done.
    assign err_now   = (state_q == WAIT2) && (err_q || mem_err);

    assign i_grant   = in_txn && (owner_q == OWNER_I);
    assign d_grant   = in_txn && (owner_q == OWNER_D);
    assign i_done    = (state_q == WAIT2) && (owner_q == OWNER_I);
    assign d_done    = (state_q == WAIT2) && (owner_q == OWNER_D);
    assign i_err     = err_now && (owner_q == OWNER_I);
    assign d_err     = err_now && (owner_q == OWNER_D);
    assign mem_rd    = (state_q == ISSUE) && can_issue && !wr_q;
    assign mem_wr    = (state_q == ISSUE) && can_issue && wr_q;
    assign mem_addr  = in_txn ? addr_q  : 16'h0000;
    assign mem_wdata = in_txn ? wdata_q : 16'h0000;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-timeline model plus directed scenarios.
// Build option ARB_FIXED_PRIO_EN switches the expected tie-break to fixed data priority.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = 16'h0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = 16'h0;
    logic [15:0] d_wdata = 16'h0;
    logic        i_grant, d_grant, i_done, d_done, i_err, d_err;
    logic [15:0] rdata;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic [3:0]  mem_busy = 4'h0;
    logic        mem_stall = 1'b0;
    logic        mem_err = 1'b0;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .i_grant   (i_grant),
        .d_grant   (d_grant),
        .i_done    (i_done),
        .d_done    (d_done),
        .i_err     (i_err),
        .d_err     (d_err),
        .rdata     (rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .mem_stall (mem_stall),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Transaction timeline model: one transaction at a time, positions counted in cycles.
    logic        tAct = 1'b0;
    logic        tOwner = 1'b0;
    logic        tWr = 1'b0;
    logic        tErr = 1'b0;
    logic [15:0] tAddr = 16'h0;
    logic [15:0] tWdata = 16'h0;
    int          tIssue = -1;
    logic        mLast = 1'b0;
    logic [15:0] mRdata = 16'h0;
    logic [15:0] rdNext;
    logic [1:0]  tBank;
    logic        eIg, eDg, eId, eDd, eIe, eDe, eRd, eWr;
    logic [15:0] eAddr, eWdata, eRdata;

    // Observed DUT events, pinned against hand-computed values by the scenarios.
    logic        prevGrant = 1'b0;
    logic        grantLog[$];
    int          evGrantCyc = 0;
    int          evIssueCyc = 0;
    int          evDoneCyc = 0;
    int          evIssueCount = 0;

    always @(negedge clk) begin
        {eIg, eDg, eId, eDd, eIe, eDe, eRd, eWr} = 8'h00;
        eAddr  = 16'h0;
        eWdata = 16'h0;
        eRdata = mRdata;
        rdNext = mRdata;
        if (rst) begin
            tAct   = 1'b0;
            mLast  = 1'b0;
            mRdata = 16'h0;
            eRdata = 16'h0;
            rdNext = 16'h0;
        end else if (!tAct) begin
            if (i_req || d_req) begin
                if (i_req && d_req) begin
`ifdef ARB_FIXED_PRIO_EN
                    tOwner = 1'b1;
`else
                    tOwner = ~mLast;
`endif
                end else begin
                    tOwner = d_req;
                end
                mLast  = tOwner;
                tAct   = 1'b1;
                tIssue = -1;
                tErr   = 1'b0;
                tAddr  = tOwner ? d_addr : i_addr;
                tWr    = tOwner & d_wr;
                tWdata = tOwner ? d_wdata : 16'h0;
            end
        end else begin
            eIg    = ~tOwner;
            eDg    = tOwner;
            eAddr  = tAddr;
            eWdata = tWdata;
            tBank  = tAddr[2:1];
            if (tIssue < 0) begin
                if (!mem_busy[tBank] && !mem_stall) begin
                    eRd    = ~tWr;
                    eWr    = tWr;
                    tIssue = cyc;
                end
            end else begin
                tErr = tErr | mem_err;
                if (cyc == tIssue + LAT) begin
                    eId  = ~tOwner;
                    eDd  = tOwner;
                    eIe  = ~tOwner & tErr;
                    eDe  = tOwner & tErr;
                    if (!tWr) rdNext = mem_rdata;
                    tAct = 1'b0;
                end
            end
        end
        checkOutput("i_grant", i_grant, eIg);
        checkOutput("d_grant", d_grant, eDg);
        checkOutput("i_done", i_done, eId);
        checkOutput("d_done", d_done, eDd);
        checkOutput("i_err", i_err, eIe);
        checkOutput("d_err", d_err, eDe);
        checkOutput("mem_rd", mem_rd, eRd);
        checkOutput("mem_wr", mem_wr, eWr);
        checkOutput("mem_addr", mem_addr, eAddr);
        checkOutput("mem_wdata", mem_wdata, eWdata);
        checkOutput("rdata", rdata, eRdata);
        mRdata = rdNext;

        if ((i_grant || d_grant) && !prevGrant) begin
            grantLog.push_back(d_grant);
            evGrantCyc = cyc;
        end
        prevGrant = i_grant | d_grant;
        if (mem_rd || mem_wr) begin
            evIssueCyc = cyc;
            evIssueCount++;
        end
        if (i_done || d_done) evDoneCyc = cyc;
    end

    task automatic waitDone(input string what);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(i_done || d_done) && n < 60);
        if (!(i_done || d_done)) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL %s timeout: no done within 60 cycles, required a done pulse", what);
        end
    endtask

    task automatic waitIssue(input string what);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(mem_rd || mem_wr) && n < 30);
        if (!(mem_rd || mem_wr)) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL %s timeout: no memory command within 30 cycles, required one", what);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        logic [3:0] seq;
        logic [3:0] seqExp;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ctrl", {i_grant, d_grant, i_done, d_done, i_err, d_err, mem_rd, mem_wr}, 32'h0);
        checkOutput("rst_addr", {mem_addr, mem_wdata}, 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);

        // Simultaneous requests from reset, held across four transactions
        nextCycle();
        i_req     = 1'b1;
        i_addr    = 16'h0100;
        d_req     = 1'b1;
        d_wr      = 1'b0;
        d_addr    = 16'h0022;
        mem_rdata = 16'h1234;
        grantLog.delete();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) waitDone("rr_seq");
        nextCycle();
        i_req = 1'b0;
        d_req = 1'b0;
        checkOutput("rr_count", grantLog.size(), 4);
        seq = 4'h0;
        for (int k = 0; k < 4 && k < grantLog.size(); k++) seq[3-k] = grantLog[k];
`ifdef ARB_FIXED_PRIO_EN
        seqExp = 4'b1111;
`else
        seqExp = 4'b1010;
`endif
        checkOutput("rr_owners", seq, seqExp);

        // Data read latency: issue T, done T+2, rdata valid T+3
        nextCycle();
        d_req     = 1'b1;
        d_wr      = 1'b0;
        d_addr    = 16'h0010;
        mem_rdata = 16'hBEEF;
        waitDone("rd_beef");
        checkOutput("rd_lat", evDoneCyc - evIssueCyc, 2);
        nextCycle();
        d_req     = 1'b0;
        mem_rdata = 16'h0000;
        checkOutput("rd_beef", rdata, 16'hBEEF);

        // Write to bank 2 held off by a busy bank for three cycles
        nextCycle();
        d_req    = 1'b1;
        d_wr     = 1'b1;
        d_addr   = 16'h0004;
        d_wdata  = 16'hA5A5;
        mem_busy = 4'b0100;
        repeat (4) @(posedge clk);
        #1;
        mem_busy = 4'b0000;
        waitDone("wr_busy");
        checkOutput("wr_held", evIssueCyc - evGrantCyc, 3);
        checkOutput("wr_lat", evDoneCyc - evIssueCyc, 2);
        nextCycle();
        d_req = 1'b0;
        d_wr  = 1'b0;

        // Instruction read with a memory error during WAIT1, then a clean stalled read
        nextCycle();
        i_req     = 1'b1;
        i_addr    = 16'h0008;
        mem_rdata = 16'hC0DE;
        waitIssue("err_issue");
        nextCycle();
        mem_err = 1'b1;
        nextCycle();
        mem_err = 1'b0;
        waitDone("err_done");
        checkOutput("err_pulse", {i_err, i_done}, 2'b11);
        nextCycle();
        i_addr    = 16'h000A;
        mem_stall = 1'b1;
        mem_rdata = 16'h0F0F;
        repeat (3) @(posedge clk);
        #1;
        mem_stall = 1'b0;
        waitDone("clean_done");
        checkOutput("clean_pulse", {i_err, i_done}, 2'b01);
        nextCycle();
        i_req = 1'b0;
        checkOutput("clean_rdata", rdata, 16'h0F0F);

        // Reset in WAIT1 with both sides pending
        nextCycle();
        d_req     = 1'b1;
        d_addr    = 16'h0012;
        mem_rdata = 16'h5555;
        waitDone("pre_rst");
        nextCycle();
        d_req = 1'b0;
        nextCycle();
        i_req   = 1'b1;
        i_addr  = 16'h0030;
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h0040;
        d_wdata = 16'h1111;
        waitIssue("rst_issue");
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst_mid_ctrl", {i_grant, d_grant, i_done, d_done, i_err, d_err, mem_rd, mem_wr}, 32'h0);
        checkOutput("rst_mid_addr", {mem_addr, mem_wdata}, 32'h0);
        nextCycle();
        grantLog.delete();
        evIssueCount = 0;
        rst = 1'b0;
        waitDone("post_rst_d");
        checkOutput("post_rst_issues", evIssueCount, 1);
        checkOutput("post_rst_owner", grantLog.size() > 0 ? grantLog[0] : 1'b0, 1'b1);
        nextCycle();
        d_req = 1'b0;
        d_wr  = 1'b0;
        waitDone("post_rst_i");
        nextCycle();
        i_req = 1'b0;
        checkOutput("post_rst_second", grantLog.size() > 1 ? grantLog[1] : 1'b1, 1'b0);
        repeat (3) nextCycle();
    endtask

    initial begin
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
